// File: rtl/alu_sequencer.sv
// ALU micro-sequencer: latches one instruction, decodes it, and drives
// one-hot ALU strobes, register selects, write-back and completion pulses.
module alu_sequencer #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] instr,
  output logic        busy,
  output logic        AND,
  output logic        OR,
  output logic        ADD,
  output logic        SUB,
  output logic        MUL,
  output logic        DIV,
  output logic        SHR,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        NEG,
  output logic        NOT,
  output logic [3:0]  ra_sel,
  output logic [3:0]  rb_sel,
  output logic [3:0]  rd_sel,
  output logic        wb_en,
  output logic        done,
  output logic        err
);

  // Zero-length parameters still yield a one-cycle strobe
  localparam int MC = (MUL_CYCLES < 1) ? 1 : MUL_CYCLES;
  localparam int DC = (DIV_CYCLES < 1) ? 1 : DIV_CYCLES;
  localparam int MX = (MC > DC) ? MC : DC;
  localparam int CW = $clog2(MX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_FIN,
    S_ERR
  } state_t;

  state_t        r_state;
  logic [4:0]    r_op;
  logic [3:0]    r_rd;
  logic [3:0]    r_ra;
  logic [3:0]    r_rb;
  logic [CW-1:0] r_cnt;
  logic [11:0]   r_strb;
  logic [3:0]    r_ra_sel;
  logic [3:0]    r_rb_sel;
  logic [3:0]    r_rd_sel;
  logic          r_wb;
  logic          r_done;
  logic          r_err;
  logic          r_busy;

  logic          w_legal;
  logic [CW-1:0] w_len;
  logic [11:0]   w_onehot;
  logic          w_unused;

  assign w_unused = ^instr[14:0];
  assign w_legal  = (r_op < 5'd12);
  assign w_onehot = 12'b1 << r_op[3:0];

  always_comb begin
    w_len = CW'(1);
    if (r_op == 5'd4)
      w_len = CW'(MC);
    else if (r_op == 5'd5)
      w_len = CW'(DC);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_rd     <= '0;
      r_ra     <= '0;
      r_rb     <= '0;
      r_cnt    <= '0;
      r_strb   <= '0;
      r_ra_sel <= '0;
      r_rb_sel <= '0;
      r_rd_sel <= '0;
      r_wb     <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= instr[31:27];
            r_rd    <= instr[26:23];
            r_ra    <= instr[22:19];
            r_rb    <= instr[18:15];
            r_busy  <= 1'b1;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_legal) begin
            r_cnt    <= w_len;
            r_strb   <= w_onehot;
            r_ra_sel <= r_ra;
            r_rb_sel <= r_rb;
            r_state  <= S_EXEC;
          end else begin
            r_err   <= 1'b1;
            r_state <= S_ERR;
          end
        end
        S_EXEC: begin
          if (r_cnt <= CW'(1)) begin
            r_cnt    <= '0;
            r_strb   <= '0;
            r_ra_sel <= '0;
            r_rb_sel <= '0;
            r_wb     <= 1'b1;
            r_rd_sel <= r_rd;
            r_state  <= S_WB;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_WB: begin
          r_wb     <= 1'b0;
          r_rd_sel <= '0;
          r_done   <= 1'b1;
          r_state  <= S_FIN;
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_ERR: begin
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign {NOT, NEG, ROL, ROR, SHL, SHR,
          DIV, MUL, SUB, ADD, OR, AND} = r_strb;

  assign busy   = r_busy;
  assign ra_sel = r_ra_sel;
  assign rb_sel = r_rb_sel;
  assign rd_sel = r_rd_sel;
  assign wb_en  = r_wb;
  assign done   = r_done;
  assign err    = r_err;

endmodule
